// File: rtl/pulse_train_generator.sv
// Programmable pulse-train generator: after a delay, emits N pulses (or a continuous
// train) of programmable width and period with selectable output polarity and abort.
module pulse_train_generator #(
    parameter int CNT_W = 32,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay_cycles,
    input  logic [CNT_W-1:0] pulse_width_cycles,
    input  logic [CNT_W-1:0] period_cycles,
    input  logic [IDX_W-1:0] pulse_count,
    input  logic             polarity,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] pulse_index,
    output logic             pulse_led,
    output logic             delay_led
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] width_m1_r;
    logic [CNT_W-1:0] gap_m1_r;
    logic [IDX_W-1:0] count_r;
    logic [IDX_W-1:0] index_r;
    logic [IDX_W-1:0] index_next_s;
    logic             pol_r;
    logic             done_r;
    logic             done_next_s;
    logic             accept_s;
    logic             last_pulse_s;
    logic [CNT_W-1:0] width_eff_s;
    logic [CNT_W-1:0] width_m1_s;
    logic [CNT_W-1:0] gap_m1_s;

    // Normalise the programmed timing; phase lengths are stored minus one so the
    // down-counter expires on zero and never has to go below it.
    always_comb begin
        width_eff_s = pulse_width_cycles;
        gap_m1_s    = CNT_ZERO;
        if (pulse_width_cycles == CNT_ZERO) begin
            width_eff_s = CNT_ONE;
        end else begin
            width_eff_s = pulse_width_cycles;
        end
        width_m1_s = width_eff_s - CNT_ONE;
        // A period not longer than the pulse collapses to a one-cycle gap.
        if (period_cycles <= width_eff_s) begin
            gap_m1_s = CNT_ZERO;
        end else begin
            gap_m1_s = period_cycles - width_eff_s - CNT_ONE;
        end
    end

    assign accept_s     = (state_r == ST_IDLE) && start && !abort;
    assign last_pulse_s = (count_r != IDX_ZERO) && (index_r == count_r);

    // Next-state, counter and pulse index logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        index_next_s = index_r;
        done_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (delay_cycles != CNT_ZERO) begin
                        state_next_s = ST_DELAY;
                        cnt_next_s   = delay_cycles - CNT_ONE;
                        index_next_s = IDX_ZERO;
                    end else begin
                        state_next_s = ST_HIGH;
                        cnt_next_s   = width_m1_s;
                        index_next_s = IDX_ONE;
                    end
                end else begin
                    cnt_next_s = CNT_ZERO;
                end
            end
            ST_DELAY: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_HIGH;
                    cnt_next_s   = width_m1_r;
                    index_next_s = index_r + IDX_ONE;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_ZERO) begin
                    if (last_pulse_s) begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = CNT_ZERO;
                        done_next_s  = 1'b1;
                    end else begin
                        state_next_s = ST_LOW;
                        cnt_next_s   = gap_m1_r;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_HIGH;
                    cnt_next_s   = width_m1_r;
                    index_next_s = index_r + IDX_ONE;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, index and completion strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            index_r <= IDX_ZERO;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            index_r <= index_next_s;
            done_r  <= done_next_s;
        end
    end

    // Burst configuration snapshot taken on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width_m1_r <= CNT_ZERO;
            gap_m1_r   <= CNT_ZERO;
            count_r    <= IDX_ZERO;
            pol_r      <= 1'b0;
        end else if (accept_s) begin
            width_m1_r <= width_m1_s;
            gap_m1_r   <= gap_m1_s;
            count_r    <= pulse_count;
            pol_r      <= polarity;
        end else begin
            width_m1_r <= width_m1_r;
            gap_m1_r   <= gap_m1_r;
            count_r    <= count_r;
            pol_r      <= pol_r;
        end
    end

    assign busy        = (state_r != ST_IDLE);
    assign pulse_led   = (state_r == ST_HIGH);
    assign delay_led   = (state_r == ST_DELAY);
    assign done        = done_r;
    assign pulse_index = index_r;

    // Idle level follows the live polarity pin; during a burst the latched one is used.
    always_comb begin
        if (state_r == ST_IDLE) begin
            pulse_out = polarity;
        end else begin
            pulse_out = pol_r ^ (state_r == ST_HIGH);
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Scoreboard bench for pulse_train_generator: bursts are described arithmetically and
// a negedge monitor compares every cycle plus pulse edge / done events against them.
module tb_pulse_train_generator;

    localparam longint INF = 64'sh3FFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] delay_cycles = 32'd0;
    logic [31:0] pulse_width_cycles = 32'd0;
    logic [31:0] period_cycles = 32'd0;
    logic [15:0] pulse_count = 16'd0;
    logic        polarity = 1'b0;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic [15:0] pulse_index;
    logic        pulse_led;
    logic        delay_led;

    pulse_train_generator #(.CNT_W(32), .IDX_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .delay_cycles(delay_cycles), .pulse_width_cycles(pulse_width_cycles),
        .period_cycles(period_cycles), .pulse_count(pulse_count), .polarity(polarity),
        .pulse_out(pulse_out), .busy(busy), .done(done), .pulse_index(pulse_index),
        .pulse_led(pulse_led), .delay_led(delay_led)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { longint t0; longint d; longint we; longint pe; longint n; longint ta; logic pol; } burst_t;
    typedef struct { int kind; longint at; longint idx; } ev_t;   // kind 0 rise, 1 fall, 2 done

    burst_t bursts[$];
    ev_t    evq[$];
    int     checks = 0;
    int     passes = 0;
    bit     fin_req = 1'b0;
    bit     fin_done = 1'b0;
    logic   mon_prev_led = 1'b0;
    logic   mon_prev_rst = 1'b1;
    ev_t    mon_ev;
    longint mon_c;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    function automatic longint b_tend(input burst_t b);
        return (b.n == 0) ? INF : b.t0 + b.d + (b.n - 1) * b.pe + b.we;
    endfunction

    function automatic longint b_end(input burst_t b);
        longint te = b_tend(b);
        return (te < b.ta) ? te : b.ta;
    endfunction

    function automatic int find_b(input longint c);
        for (int i = bursts.size() - 1; i >= 0; i--)
            if (bursts[i].t0 <= c) return i;
        return -1;
    endfunction

    function automatic bit exp_busy(input longint c);
        int i = find_b(c);
        if (i < 0) return 1'b0;
        return c < b_end(bursts[i]);
    endfunction

    function automatic bit exp_high(input longint c);
        int i = find_b(c);
        burst_t b;
        if (i < 0) return 1'b0;
        b = bursts[i];
        if (c < b.t0 + b.d || c >= b_end(b)) return 1'b0;
        return ((c - b.t0 - b.d) % b.pe) < b.we;
    endfunction

    function automatic bit exp_dly(input longint c);
        int i = find_b(c);
        if (i < 0) return 1'b0;
        return (c < bursts[i].t0 + bursts[i].d) && (c < b_end(bursts[i]));
    endfunction

    function automatic longint exp_idx(input longint c);
        int i = find_b(c);
        burst_t b;
        longint last;
        longint cnt;
        if (i < 0) return 0;
        b = bursts[i];
        last = (c > b.ta - 1) ? b.ta - 1 : c;
        cnt = (last < b.t0 + b.d) ? 0 : (last - b.t0 - b.d) / b.pe + 1;
        if (b.n != 0 && cnt > b.n) cnt = b.n;
        return cnt % 65536;
    endfunction

    function automatic bit exp_done(input longint c);
        int i = find_b(c);
        if (i < 0) return 1'b0;
        return (bursts[i].n != 0) && (b_tend(bursts[i]) < bursts[i].ta) && (c == b_tend(bursts[i]));
    endfunction

    function automatic bit exp_pout(input longint c);
        int i = find_b(c);
        if (i >= 0 && exp_busy(c)) return bursts[i].pol ^ exp_high(c);
        return polarity;
    endfunction

    task automatic add_burst(input longint t0, input longint d, input longint w, input longint p,
                             input longint n, input logic pol);
        burst_t b;
        longint kmax;
        ev_t e;
        b.t0 = t0; b.d = d; b.n = n; b.pol = pol; b.ta = INF;
        b.we = (w == 0) ? 1 : w;
        b.pe = (p <= b.we) ? b.we + 1 : p;
        bursts.push_back(b);
        kmax = (n == 0) ? (4000 / b.pe + 1) : n;
        for (longint k = 1; k <= kmax; k++) begin
            e.kind = 0; e.at = t0 + d + (k - 1) * b.pe; e.idx = k % 65536; evq.push_back(e);
            e.kind = 1; e.at = e.at + b.we; e.idx = 0; evq.push_back(e);
        end
        if (n != 0) begin
            e.kind = 2; e.at = b_tend(b); e.idx = n % 65536; evq.push_back(e);
        end
    endtask

    task automatic apply_abort(input longint ta);
        burst_t b;
        ev_t keep[$];
        ev_t e;
        b = bursts[bursts.size() - 1];
        void'(bursts.pop_back());
        b.ta = ta;
        bursts.push_back(b);
        foreach (evq[i]) if (evq[i].at < ta) keep.push_back(evq[i]);
        evq = keep;
        if (exp_high(ta - 1)) begin
            e.kind = 1; e.at = ta; e.idx = 0; evq.push_back(e);
        end
    endtask

    task automatic drive_cfg(input longint d, input longint w, input longint p, input longint n, input logic pol);
        delay_cycles = d[31:0];
        pulse_width_cycles = w[31:0];
        period_cycles = p[31:0];
        pulse_count = n[15:0];
        polarity = pol;
    endtask

    task automatic run_burst(input longint d, input longint w, input longint p, input longint n,
                             input logic pol, input longint abort_off, input bit noise, input bit coinc);
        longint t0;
        longint te;
        @(negedge clk); #1;
        drive_cfg(d, w, p, n, pol);
        start = 1'b1;
        t0 = cyc + 1;
        add_burst(t0, d, w, p, n, pol);
        te = b_tend(bursts[bursts.size() - 1]);
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (noise) begin
                if ($urandom_range(0, 3) == 0)
                    drive_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                if (exp_busy(cyc) && $urandom_range(0, 5) == 0) start = 1'b1;
            end
            if (coinc && cyc == te - 1) start = 1'b1;
            if (abort_off != 0 && cyc == t0 + abort_off - 1 && exp_busy(cyc)) begin
                abort = 1'b1;
                apply_abort(t0 + abort_off);
            end
            if (cyc >= t0 && !exp_busy(cyc)) break;
        end
        repeat ($urandom_range(1, 3)) begin
            @(negedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
        end
    endtask

    // Monitor: per-cycle comparison plus scoreboard events; also checks async reset.
    initial begin
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n && mon_prev_rst) begin
                mon_prev_rst = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_index", pulse_index, 0);
                chk("rst_pulse_led", pulse_led, 0);
                chk("rst_delay_led", delay_led, 0);
                chk("rst_pulse_out", pulse_out, polarity);
                mon_prev_led = 1'b0;
            end else begin
                mon_prev_rst = reset_n;
                mon_c = cyc;
                chk("busy", busy, exp_busy(mon_c));
                chk("delay_led", delay_led, exp_dly(mon_c));
                chk("pulse_led", pulse_led, exp_high(mon_c));
                chk("pulse_out", pulse_out, exp_pout(mon_c));
                chk("done", done, exp_done(mon_c));
                chk("pulse_index", pulse_index, exp_idx(mon_c));
                for (int kind = 1; kind >= 0; kind--) begin
                    if ((kind == 1 && !pulse_led && mon_prev_led) || (kind == 0 && pulse_led && !mon_prev_led)) begin
                        if (evq.size() == 0) chk("unexpected_edge", 1, 0);
                        else begin
                            mon_ev = evq.pop_front();
                            chk("ev_kind", kind, mon_ev.kind);
                            chk("ev_cycle", mon_c, mon_ev.at);
                            if (kind == 0) chk("ev_rise_index", pulse_index, mon_ev.idx);
                        end
                    end
                    if (kind == 1 && done) begin
                        if (evq.size() == 0) chk("unexpected_done", 1, 0);
                        else begin
                            mon_ev = evq.pop_front();
                            chk("ev_kind", 2, mon_ev.kind);
                            chk("ev_done_cycle", mon_c, mon_ev.at);
                            chk("ev_done_index", pulse_index, mon_ev.idx);
                        end
                    end
                end
                mon_prev_led = pulse_led;
                if (fin_req && !fin_done) begin
                    chk("events_left", evq.size(), 0);
                    fin_done = 1'b1;
                end
            end
        end
    end

    // Stimulus
    initial begin
        longint t0;
        longint te1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        run_burst(10, 20, 50, 1, 1'b0, 0, 1'b0, 1'b0);
        run_burst(0, 3, 8, 4, 1'b0, 0, 1'b0, 1'b0);
        run_burst(3, 0, 0, 2, 1'b0, 0, 1'b0, 1'b0);
        run_burst(1, 5, 5, 3, 1'b1, 0, 1'b0, 1'b0);
        run_burst(64'd4294967295, 5, 10, 1, 1'b0, 100, 1'b0, 1'b0);
        run_burst(0, 2, 4, 0, 1'b1, 22, 1'b0, 1'b0);
        run_burst(1, 3, 5, 2, 1'b0, 0, 1'b0, 1'b1);
        run_burst(3, 4, 9, 3, 1'b0, 0, 1'b1, 1'b0);

        // start held high across a completion re-triggers exactly once per burst
        @(negedge clk); #1;
        drive_cfg(2, 4, 6, 2, 1'b0);
        start = 1'b1;
        t0 = cyc + 1;
        add_burst(t0, 2, 4, 6, 2, 1'b0);
        te1 = b_tend(bursts[bursts.size() - 1]);
        add_burst(te1 + 1, 2, 4, 6, 2, 1'b0);
        for (int k = 0; k < 200 && cyc < te1 + 1; k++) begin
            @(negedge clk); #1;
        end
        start = 1'b0;
        for (int k = 0; k < 200 && exp_busy(cyc); k++) begin
            @(negedge clk); #1;
        end

        // asynchronous reset in the LOW phase, between clock edges
        @(negedge clk); #1;
        drive_cfg(4, 2, 10, 3, 1'b0);
        start = 1'b1;
        t0 = cyc + 1;
        add_burst(t0, 4, 2, 10, 3, 1'b0);
        @(negedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && cyc < t0 + 9; k++) begin
            @(negedge clk); #1;
        end
        #1 reset_n = 1'b0;
        bursts.delete();
        evq.delete();
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        run_burst(10, 20, 50, 1, 1'b0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            longint d = $urandom_range(0, 12);
            longint w = $urandom_range(0, 6);
            longint p = $urandom_range(0, 14);
            longint n = $urandom_range(0, 4);
            longint ab = (n == 0 || $urandom_range(0, 3) == 0) ? longint'($urandom_range(1, 60)) : 0;
            run_burst(d, w, p, n, 1'($urandom_range(0, 1)), ab, 1'($urandom_range(0, 1)), 1'b0);
        end

        fin_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
